// File: rtl/xge_tx_arb_pkg.sv
// Shared types, constants and the round-robin pick function for the
// xge_mac packet-TX arbiter and related traffic blocks.
package xge_tx_arb_pkg;

  // Beat payload widths of the xge_mac packet interface.
  localparam int DATA_W  = 64;
  localparam int MOD_W   = 3;

  // Requester indices are carried in a fixed 3-bit field so grant_id keeps
  // the same width for every NUM_REQ in the supported 2..8 range.
  localparam int IDX_W   = 3;
  localparam int MAX_REQ = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // Round-robin search: first set bit of req starting at last+1 and wrapping
  // modulo n. The double loop compares against elaboration-time constants
  // only, so it flattens into a plain priority mux.
  function automatic rr_pick_t rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [IDX_W-1:0]   last,
    input int                 n
  );
    rr_pick_t res;
    res.found = 1'b0;
    res.idx   = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      for (int j = 0; j < MAX_REQ; j++) begin
        if (!res.found && (k <= n) && (j == ((int'(last) + k) % n)) && req[j]) begin
          res.found = 1'b1;
          res.idx   = IDX_W'(j);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/xge_rr_arbiter.sv
// Combinational round-robin picker: request vector and last-granted pointer
// in, winning index and a found flag out. No state; the caller owns the
// pointer so the same picker can serve a future RX distributor.
module xge_rr_arbiter
  import xge_tx_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] pick,
  output logic             found
);

  logic [MAX_REQ-1:0] req_pad;
  rr_pick_t           res;

  // Widen the request vector to the function's fixed width and search it.
  always_comb begin
    req_pad        = '0;
    req_pad[N-1:0] = req;
    res            = rr_pick(req_pad, last, N);
    pick           = res.idx;
    found          = res.found;
  end

endmodule

// File: rtl/xge_tx_arbiter.sv
// Packet-level round-robin arbiter in front of the xge_mac TX interface.
// A grant lasts for a whole packet (sop..eop), beats go through a single
// registered output stage, and pkt_tx_full throttles the granted source
// combinationally through req_ready.
module xge_tx_arbiter
  import xge_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
) (
  input  logic                       clk_156m25,
  input  logic                       reset_156m25_n,
  input  logic [NUM_REQ-1:0]         req_val,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_sop,
  input  logic [NUM_REQ-1:0]         req_eop,
  input  logic [NUM_REQ*MOD_W-1:0]   req_mod,
  input  logic [NUM_REQ-1:0]         req_enable,
  input  logic                       pkt_tx_full,
  output logic [DATA_W-1:0]          pkt_tx_data,
  output logic                       pkt_tx_sop,
  output logic                       pkt_tx_eop,
  output logic [MOD_W-1:0]           pkt_tx_mod,
  output logic                       pkt_tx_val,
  output logic [IDX_W-1:0]           grant_id,
  output logic                       busy,
  output logic                       sop_err,
  output logic [NUM_REQ*CNT_W-1:0]   pkt_cnt
);

  // Control state
  arb_state_t       state_reg, state_next;
  logic [IDX_W-1:0] grant_reg;
  logic [IDX_W-1:0] last_reg;
  logic             first_beat_reg;

  // Registered MAC-side beat
  logic [DATA_W-1:0] tx_data_reg;
  logic              tx_sop_reg;
  logic              tx_eop_reg;
  logic [MOD_W-1:0]  tx_mod_reg;
  logic              tx_val_reg;
  logic              sop_err_reg;

  // Per-requester completed-packet counters
  logic [CNT_W-1:0]  cnt_reg [NUM_REQ];

  // Arbitration
  logic [NUM_REQ-1:0] cand;
  logic [IDX_W-1:0]   pick;
  logic               pick_found;

  // Beat presented by the granted requester
  logic               sel_val;
  logic               sel_sop;
  logic               sel_eop;
  logic [MOD_W-1:0]   sel_mod;
  logic [DATA_W-1:0]  sel_data;
  logic               accept;

  // Masked-off requesters are invisible to the picker; the mask is only
  // consulted here, so clearing it mid-packet never cuts a packet short.
  assign cand = req_val & req_enable;

  xge_rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .req   (cand),
    .last  (last_reg),
    .pick  (pick),
    .found (pick_found)
  );

  // Steer the granted requester's beat onto the shared select bus.
  always_comb begin
    sel_val  = 1'b0;
    sel_sop  = 1'b0;
    sel_eop  = 1'b0;
    sel_mod  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_reg == IDX_W'(i)) begin
        sel_val  = req_val[i];
        sel_sop  = req_sop[i];
        sel_eop  = req_eop[i];
        sel_mod  = req_mod[i*MOD_W +: MOD_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: a found candidate opens a grant, an accepted eop closes it.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pick_found) state_next = XFER;
      XFER:    if (accept && sel_eop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: ready only for the granted source and only while the MAC
  // has room, so a beat is never taken in a full cycle.
  always_comb begin
    req_ready = '0;
    busy      = 1'b0;
    accept    = 1'b0;
    if (state_reg == XFER) begin
      busy = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_reg == IDX_W'(i)) begin
          req_ready[i] = req_val[i] & ~pkt_tx_full;
        end
      end
      accept = sel_val & ~pkt_tx_full;
    end
  end

  // Grant bookkeeping: latch the winner and arm first-beat sop generation.
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      grant_reg      <= '0;
      last_reg       <= IDX_W'(NUM_REQ - 1);
      first_beat_reg <= 1'b0;
    end else if ((state_reg == IDLE) && pick_found) begin
      grant_reg      <= pick;
      last_reg       <= pick;
      first_beat_reg <= 1'b1;
    end else if (accept) begin
      first_beat_reg <= 1'b0;
    end
  end

  // Output stage: register accepted beats; sop comes from the grant, not
  // from req_sop, and payload fields hold when no beat is accepted.
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      tx_val_reg  <= 1'b0;
      tx_data_reg <= '0;
      tx_sop_reg  <= 1'b0;
      tx_eop_reg  <= 1'b0;
      tx_mod_reg  <= '0;
      sop_err_reg <= 1'b0;
    end else begin
      tx_val_reg  <= accept;
      sop_err_reg <= accept & sel_sop & ~first_beat_reg;
      if (accept) begin
        tx_data_reg <= sel_data;
        tx_sop_reg  <= first_beat_reg;
        tx_eop_reg  <= sel_eop;
        tx_mod_reg  <= sel_eop ? sel_mod : '0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
      // Count completed packets per requester; natural wrap at 2^CNT_W.
      always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
          cnt_reg[gi] <= '0;
        end else if (accept && sel_eop && (grant_reg == IDX_W'(gi))) begin
          cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
        end
      end
      assign pkt_cnt[gi*CNT_W +: CNT_W] = cnt_reg[gi];
    end
  endgenerate

  assign pkt_tx_data = tx_data_reg;
  assign pkt_tx_sop  = tx_sop_reg;
  assign pkt_tx_eop  = tx_eop_reg;
  assign pkt_tx_mod  = tx_mod_reg;
  assign pkt_tx_val  = tx_val_reg;
  assign sop_err     = sop_err_reg;
  assign grant_id    = grant_reg;

endmodule

// File: tb/tb_xge_tx_arbiter.sv
// Directed bench for xge_tx_arbiter. Sources are per-requester beat FIFOs
// presented one cycle at a time; the MAC side is logged per cycle and each
// scenario task compares the logs against hand-derived expectations.
// A narrow counter width is used so the counter wrap is reached quickly.
module tb_xge_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 8;

  logic                     clk_156m25 = 1'b0;
  logic                     reset_156m25_n = 1'b0;
  logic [NUM_REQ-1:0]       req_val;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*64-1:0]    req_data;
  logic [NUM_REQ-1:0]       req_sop;
  logic [NUM_REQ-1:0]       req_eop;
  logic [NUM_REQ*3-1:0]     req_mod;
  logic [NUM_REQ-1:0]       req_enable;
  logic                     pkt_tx_full;
  logic [63:0]              pkt_tx_data;
  logic                     pkt_tx_sop;
  logic                     pkt_tx_eop;
  logic [2:0]               pkt_tx_mod;
  logic                     pkt_tx_val;
  logic [2:0]               grant_id;
  logic                     busy;
  logic                     sop_err;
  logic [NUM_REQ*CNT_W-1:0] pkt_cnt;

  always #5 clk_156m25 = ~clk_156m25;

  xge_tx_arbiter #(
    .NUM_REQ (NUM_REQ),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_156m25     (clk_156m25),
    .reset_156m25_n (reset_156m25_n),
    .req_val        (req_val),
    .req_ready      (req_ready),
    .req_data       (req_data),
    .req_sop        (req_sop),
    .req_eop        (req_eop),
    .req_mod        (req_mod),
    .req_enable     (req_enable),
    .pkt_tx_full    (pkt_tx_full),
    .pkt_tx_data    (pkt_tx_data),
    .pkt_tx_sop     (pkt_tx_sop),
    .pkt_tx_eop     (pkt_tx_eop),
    .pkt_tx_mod     (pkt_tx_mod),
    .pkt_tx_val     (pkt_tx_val),
    .grant_id       (grant_id),
    .busy           (busy),
    .sop_err        (sop_err),
    .pkt_cnt        (pkt_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Source FIFOs: beat word = {sop, eop, mod[2:0], data[63:0]}
  logic [68:0] src_mem [NUM_REQ][16];
  int          src_wr  [NUM_REQ];
  int          src_rd  [NUM_REQ];

  // Per-cycle logs, index = cycle number since the scenario started
  int                 cyc;
  logic [68:0]        out_beat[$];
  int                 out_cyc[$];
  logic [2:0]         out_gid[$];
  logic [NUM_REQ-1:0] rdy_hist[$];
  logic               val_hist[$];
  int                 err_cyc[$];

  function automatic logic [68:0] mkb(input logic s, input logic e,
                                      input logic [2:0] m, input logic [63:0] d);
    return {s, e, m, d};
  endfunction

  function automatic logic [CNT_W-1:0] cnt_of(input int i);
    return pkt_cnt[CNT_W*i +: CNT_W];
  endfunction

  task automatic push(input int r, input logic s, input logic e,
                      input logic [2:0] m, input logic [63:0] d);
    src_mem[r][src_wr[r][3:0]] = mkb(s, e, m, d);
    src_wr[r]++;
  endtask

  task automatic clear_logs();
    out_beat.delete(); out_cyc.delete(); out_gid.delete();
    rdy_hist.delete(); val_hist.delete(); err_cyc.delete();
    cyc = 0;
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NUM_REQ; i++) begin
      src_wr[i] = 0;
      src_rd[i] = 0;
    end
    req_val = '0;
  endtask

  // One clock: present head beats, note ready just before the edge,
  // then log what the MAC side shows just after it.
  task automatic step();
    logic [NUM_REQ-1:0] rdy;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_rd[i] != src_wr[i]) begin
        req_val[i] = 1'b1;
        {req_sop[i], req_eop[i], req_mod[3*i +: 3], req_data[64*i +: 64]} =
          src_mem[i][src_rd[i][3:0]];
      end else begin
        req_val[i] = 1'b0;
      end
    end
    #1;
    rdy = req_ready;
    rdy_hist.push_back(rdy);
    @(posedge clk_156m25);
    #1;
    for (int i = 0; i < NUM_REQ; i++) if (rdy[i]) src_rd[i]++;
    val_hist.push_back(pkt_tx_val);
    if (pkt_tx_val) begin
      out_beat.push_back({pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data});
      out_cyc.push_back(cyc);
      out_gid.push_back(grant_id);
      $display("beat cyc=%0d gid=%0d sop=%0b eop=%0b mod=%0d data=%h",
               cyc, grant_id, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data);
    end
    if (sop_err) err_cyc.push_back(cyc);
    cyc++;
  endtask

  task automatic apply_reset();
    reset_156m25_n = 1'b0;
    pkt_tx_full = 1'b0;
    req_sop = '0; req_eop = '0; req_mod = '0; req_data = '0;
    req_enable = '1;
    clear_sources();
    repeat (2) @(posedge clk_156m25);
    #1;
    reset_156m25_n = 1'b1;
    clear_logs();
  endtask

  task automatic test_reset();
    reset_156m25_n = 1'b0;
    pkt_tx_full = 1'b0;
    req_enable = '1;
    req_val = '1;
    req_sop = '1; req_eop = '0; req_mod = '0; req_data = '1;
    repeat (2) @(posedge clk_156m25);
    #1;
    checks++; if (pkt_tx_val !== 1'b0) begin errors++; $display("FAIL reset_val: got %b want 0", pkt_tx_val); end
    checks++; if (pkt_tx_data !== 64'h0) begin errors++; $display("FAIL reset_data: got %h want 0", pkt_tx_data); end
    checks++; if ({pkt_tx_sop, pkt_tx_eop, pkt_tx_mod} !== 5'b0) begin errors++; $display("FAIL reset_ctl: got %b want 0", {pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}); end
    checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (sop_err !== 1'b0) begin errors++; $display("FAIL reset_sop_err: got %b want 0", sop_err); end
    checks++; if (pkt_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %h want 0", pkt_cnt); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    req_val = '0;
    reset_156m25_n = 1'b1;
  endtask

  task automatic test_single_req();
    logic [68:0] exp_b [3];
    logic        exp_v;
    apply_reset();
    push(0, 1'b1, 1'b0, 3'd0, 64'hA0);
    push(0, 1'b0, 1'b0, 3'd7, 64'hA1);
    push(0, 1'b0, 1'b1, 3'd5, 64'hA2);
    repeat (6) step();
    for (int k = 0; k < 6; k++) begin
      exp_v = (k >= 1 && k <= 3);
      checks++; if (val_hist[k] !== exp_v) begin errors++; $display("FAIL single_val[%0d]: got %b want %b", k, val_hist[k], exp_v); end
    end
    exp_b[0] = mkb(1'b1, 1'b0, 3'd0, 64'hA0);
    exp_b[1] = mkb(1'b0, 1'b0, 3'd0, 64'hA1);
    exp_b[2] = mkb(1'b0, 1'b1, 3'd5, 64'hA2);
    checks++; if (out_beat.size() != 3) begin errors++; $display("FAIL single_nbeats: got %0d want 3", out_beat.size()); end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (j >= out_beat.size() || out_beat[j] !== exp_b[j]) begin
        errors++; $display("FAIL single_beat[%0d]: got %h want %h", j, (j < out_beat.size()) ? out_beat[j] : 69'h0, exp_b[j]);
      end
    end
    checks++; if (cnt_of(0) !== 8'd1) begin errors++; $display("FAIL single_cnt0: got %0d want 1", cnt_of(0)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int p, b, rq, pk;
    logic [2:0]  em;
    logic [68:0] ew;
    apply_reset();
    for (int r = 0; r < NUM_REQ; r++) begin
      push(r, 1'b1, 1'b0, 3'd0, 64'(r + 1) * 64'h1000);
      push(r, 1'b0, 1'b1, 3'(r + 1), 64'(r + 1) * 64'h1000 + 64'd1);
    end
    push(0, 1'b1, 1'b0, 3'd0, 64'h1010);
    push(0, 1'b0, 1'b1, 3'd6, 64'h1011);
    repeat (16) step();
    checks++; if (out_beat.size() != 10) begin errors++; $display("FAIL b2b_nbeats: got %0d want 10", out_beat.size()); end
    for (int j = 0; j < 10 && j < out_beat.size(); j++) begin
      p  = j / 2;
      b  = j % 2;
      rq = p % 4;
      pk = p / 4;
      em = (b == 1) ? ((pk == 1) ? 3'd6 : 3'(rq + 1)) : 3'd0;
      ew = mkb(b == 0, b == 1, em, 64'(rq + 1) * 64'h1000 + 64'(16 * pk + b));
      checks++; if (out_beat[j] !== ew) begin errors++; $display("FAIL b2b_beat[%0d]: got %h want %h", j, out_beat[j], ew); end
      checks++; if (out_gid[j] !== 3'(rq)) begin errors++; $display("FAIL b2b_gid[%0d]: got %0d want %0d", j, out_gid[j], rq); end
      checks++; if (out_cyc[j] != 3 * p + 1 + b) begin errors++; $display("FAIL b2b_cyc[%0d]: got %0d want %0d", j, out_cyc[j], 3 * p + 1 + b); end
    end
    checks++; if (pkt_cnt !== {8'd1, 8'd1, 8'd1, 8'd2}) begin errors++; $display("FAIL b2b_cnt: got %h want 01010102", pkt_cnt); end
  endtask

  task automatic test_backpressure();
    logic        exp_v;
    logic [68:0] exp_b [4];
    apply_reset();
    push(2, 1'b1, 1'b0, 3'd0, 64'hD0);
    push(2, 1'b0, 1'b0, 3'd0, 64'hD1);
    push(2, 1'b0, 1'b0, 3'd0, 64'hD2);
    push(2, 1'b0, 1'b1, 3'd3, 64'hD3);
    for (int k = 0; k < 12; k++) begin
      pkt_tx_full = (k == 0) || (k >= 2 && k <= 6);
      step();
    end
    pkt_tx_full = 1'b0;
    for (int k = 0; k < 12; k++) begin
      exp_v = (k == 1) || (k >= 7 && k <= 9);
      checks++; if (rdy_hist[k][2] !== exp_v) begin errors++; $display("FAIL bp_ready2[%0d]: got %b want %b", k, rdy_hist[k][2], exp_v); end
      checks++; if (val_hist[k] !== exp_v) begin errors++; $display("FAIL bp_val[%0d]: got %b want %b", k, val_hist[k], exp_v); end
    end
    exp_b[0] = mkb(1'b1, 1'b0, 3'd0, 64'hD0);
    exp_b[1] = mkb(1'b0, 1'b0, 3'd0, 64'hD1);
    exp_b[2] = mkb(1'b0, 1'b0, 3'd0, 64'hD2);
    exp_b[3] = mkb(1'b0, 1'b1, 3'd3, 64'hD3);
    checks++; if (out_beat.size() != 4) begin errors++; $display("FAIL bp_nbeats: got %0d want 4", out_beat.size()); end
    for (int j = 0; j < 4 && j < out_beat.size(); j++) begin
      checks++; if (out_beat[j] !== exp_b[j]) begin errors++; $display("FAIL bp_beat[%0d]: got %h want %h", j, out_beat[j], exp_b[j]); end
    end
  endtask

  task automatic test_single_beat_wrap();
    int n = 0;
    int guard = 0;
    int bad = 0;
    logic [68:0] ew;
    apply_reset();
    while (out_beat.size() < 255 && guard < 1000) begin
      if (src_wr[1] - src_rd[1] < 8) begin
        push(1, 1'b1, 1'b1, 3'(n), 64'h5100 + 64'(n));
        n++;
      end
      step();
      guard++;
    end
    checks++; if (out_beat.size() != 255) begin errors++; $display("FAIL wrap_n255: got %0d want 255", out_beat.size()); end
    checks++; if (cnt_of(1) !== 8'hFF) begin errors++; $display("FAIL wrap_cnt_ff: got %h want ff", cnt_of(1)); end
    while (out_beat.size() < 256 && guard < 1000) begin
      if (src_wr[1] - src_rd[1] < 8) begin
        push(1, 1'b1, 1'b1, 3'(n), 64'h5100 + 64'(n));
        n++;
      end
      step();
      guard++;
    end
    checks++; if (out_beat.size() != 256) begin errors++; $display("FAIL wrap_n256: got %0d want 256", out_beat.size()); end
    checks++; if (cnt_of(1) !== 8'h00) begin errors++; $display("FAIL wrap_cnt_00: got %h want 00", cnt_of(1)); end
    checks++; if (cnt_of(0) !== 8'h00) begin errors++; $display("FAIL wrap_cnt0: got %h want 00", cnt_of(0)); end
    for (int j = 0; j < out_beat.size(); j++) begin
      ew = mkb(1'b1, 1'b1, 3'(j), 64'h5100 + 64'(j));
      if (out_beat[j] !== ew) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL wrap_beats: got %0d bad beats want 0", bad); end
  endtask

  task automatic test_reset_mid_packet();
    logic [68:0] exp_b [4];
    logic [2:0]  exp_g [4];
    apply_reset();
    push(3, 1'b1, 1'b0, 3'd0, 64'hF0);
    push(3, 1'b0, 1'b0, 3'd0, 64'hF1);
    push(3, 1'b0, 1'b0, 3'd0, 64'hF2);
    push(3, 1'b0, 1'b1, 3'd1, 64'hF3);
    repeat (3) step();
    checks++; if ({pkt_tx_val, pkt_tx_data} !== {1'b1, 64'hF1}) begin errors++; $display("FAIL rst_mid_pre: got %b/%h want 1/f1", pkt_tx_val, pkt_tx_data); end
    reset_156m25_n = 1'b0;
    #1;
    checks++; if (pkt_tx_val !== 1'b0) begin errors++; $display("FAIL rst_mid_val: got %b want 0", pkt_tx_val); end
    checks++; if ({pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod} !== 69'h0) begin errors++; $display("FAIL rst_mid_beat: got %h want 0", {pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}); end
    checks++; if ({busy, grant_id, sop_err} !== 5'b0) begin errors++; $display("FAIL rst_mid_ctl: got %b want 0", {busy, grant_id, sop_err}); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL rst_mid_ready: got %b want 0", req_ready); end
    clear_sources();
    @(posedge clk_156m25);
    #1;
    reset_156m25_n = 1'b1;
    clear_logs();
    push(0, 1'b1, 1'b0, 3'd0, 64'hC0);
    push(0, 1'b0, 1'b1, 3'd2, 64'hC1);
    push(3, 1'b1, 1'b0, 3'd0, 64'hE0);
    push(3, 1'b0, 1'b1, 3'd3, 64'hE1);
    repeat (8) step();
    exp_b[0] = mkb(1'b1, 1'b0, 3'd0, 64'hC0); exp_g[0] = 3'd0;
    exp_b[1] = mkb(1'b0, 1'b1, 3'd2, 64'hC1); exp_g[1] = 3'd0;
    exp_b[2] = mkb(1'b1, 1'b0, 3'd0, 64'hE0); exp_g[2] = 3'd3;
    exp_b[3] = mkb(1'b0, 1'b1, 3'd3, 64'hE1); exp_g[3] = 3'd3;
    checks++; if (out_beat.size() != 4) begin errors++; $display("FAIL rst_after_nbeats: got %0d want 4", out_beat.size()); end
    for (int j = 0; j < 4 && j < out_beat.size(); j++) begin
      checks++; if (out_beat[j] !== exp_b[j]) begin errors++; $display("FAIL rst_after_beat[%0d]: got %h want %h", j, out_beat[j], exp_b[j]); end
      checks++; if (out_gid[j] !== exp_g[j]) begin errors++; $display("FAIL rst_after_gid[%0d]: got %0d want %0d", j, out_gid[j], exp_g[j]); end
    end
  endtask

  task automatic test_enable_mask_sop_err();
    logic [68:0] exp_b [6];
    logic [2:0]  exp_g [6];
    apply_reset();
    req_enable = 4'b1011;
    push(0, 1'b1, 1'b0, 3'd0, 64'h70);
    push(0, 1'b1, 1'b1, 3'd2, 64'h71);
    push(1, 1'b1, 1'b0, 3'd0, 64'h80);
    push(1, 1'b0, 1'b1, 3'd1, 64'h81);
    push(2, 1'b1, 1'b0, 3'd0, 64'h90);
    push(2, 1'b0, 1'b1, 3'd7, 64'h91);
    push(3, 1'b0, 1'b0, 3'd0, 64'hB0);
    push(3, 1'b0, 1'b1, 3'd4, 64'hB1);
    for (int k = 0; k < 12; k++) begin
      if (k == 4) req_enable = 4'b1001;
      step();
    end
    exp_b[0] = mkb(1'b1, 1'b0, 3'd0, 64'h70); exp_g[0] = 3'd0;
    exp_b[1] = mkb(1'b0, 1'b1, 3'd2, 64'h71); exp_g[1] = 3'd0;
    exp_b[2] = mkb(1'b1, 1'b0, 3'd0, 64'h80); exp_g[2] = 3'd1;
    exp_b[3] = mkb(1'b0, 1'b1, 3'd1, 64'h81); exp_g[3] = 3'd1;
    exp_b[4] = mkb(1'b1, 1'b0, 3'd0, 64'hB0); exp_g[4] = 3'd3;
    exp_b[5] = mkb(1'b0, 1'b1, 3'd4, 64'hB1); exp_g[5] = 3'd3;
    checks++; if (out_beat.size() != 6) begin errors++; $display("FAIL mask_nbeats: got %0d want 6", out_beat.size()); end
    for (int j = 0; j < 6 && j < out_beat.size(); j++) begin
      checks++; if (out_beat[j] !== exp_b[j]) begin errors++; $display("FAIL mask_beat[%0d]: got %h want %h", j, out_beat[j], exp_b[j]); end
      checks++; if (out_gid[j] !== exp_g[j]) begin errors++; $display("FAIL mask_gid[%0d]: got %0d want %0d", j, out_gid[j], exp_g[j]); end
    end
    checks++; if (err_cyc.size() != 1) begin errors++; $display("FAIL sop_err_count: got %0d want 1", err_cyc.size()); end
    checks++; if (err_cyc.size() < 1 || err_cyc[0] != 2) begin errors++; $display("FAIL sop_err_cyc: got %0d want 2", (err_cyc.size() > 0) ? err_cyc[0] : -1); end
    checks++; if (src_rd[2] != 0) begin errors++; $display("FAIL mask_req2_taken: got %0d beats want 0", src_rd[2]); end
    checks++; if ({busy, grant_id} !== {1'b0, 3'd3}) begin errors++; $display("FAIL mask_end_state: got %b want 0011", {busy, grant_id}); end
    checks++; if (pkt_cnt !== {8'd1, 8'd0, 8'd1, 8'd1}) begin errors++; $display("FAIL mask_cnt: got %h want 01000101", pkt_cnt); end
  endtask

  initial begin
    req_val = '0; req_sop = '0; req_eop = '0; req_mod = '0; req_data = '0;
    req_enable = '1; pkt_tx_full = 1'b0;
    clear_sources();
    clear_logs();
    test_reset();
    test_single_req();
    test_back_to_back();
    test_backpressure();
    test_single_beat_wrap();
    test_reset_mid_packet();
    test_enable_mask_sop_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
